// File: rtl/torus_router.sv
// torus_router: 7-port input-buffered router for a 3-D torus NoC.
// Per-input FIFOs, dimension-order (X, Y, Z) shortest-path routing with
// wrap-around, round-robin arbitration per output and a registered
// valid/ready output stage.
module torus_router #(
  parameter int FLIT_SIZE  = 32,
  parameter int DIM_X      = 10,
  parameter int DIM_Y      = 10,
  parameter int DIM_Z      = 10,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int MY_Z       = 0,
  parameter int FIFO_DEPTH = 4,
  localparam int XW        = (DIM_X > 1) ? $clog2(DIM_X) : 1,
  localparam int YW        = (DIM_Y > 1) ? $clog2(DIM_Y) : 1,
  localparam int ZW        = (DIM_Z > 1) ? $clog2(DIM_Z) : 1,
  localparam int unsigned PORTS = 7
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [PORTS*FLIT_SIZE-1:0] IN_DATA,
  input  logic [PORTS-1:0]           IN_VALID,
  output logic [PORTS-1:0]           IN_READY,
  output logic [PORTS*FLIT_SIZE-1:0] OUT_DATA,
  output logic [PORTS-1:0]           OUT_VALID,
  input  logic [PORTS-1:0]           OUT_READY
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = XW + YW + ZW;

  typedef logic [FLIT_SIZE-1:0] flit_t;
  typedef logic [AW:0]          ptr_t;

  flit_t            fifo_mem [PORTS][FIFO_DEPTH];
  ptr_t             wr_ptr_q [PORTS];
  ptr_t             wr_ptr_d [PORTS];
  ptr_t             rd_ptr_q [PORTS];
  ptr_t             rd_ptr_d [PORTS];
  logic [PORTS-1:0] full;
  logic [PORTS-1:0] empty;
  logic [PORTS-1:0] push;
  logic [PORTS-1:0] pop;
  flit_t            head       [PORTS];
  logic [2:0]       route_port [PORTS];
  logic [2:0]       rr_q       [PORTS];
  logic [2:0]       rr_d       [PORTS];
  logic [PORTS-1:0] out_valid_q;
  logic [PORTS-1:0] out_valid_d;
  flit_t            out_data_q [PORTS];
  flit_t            out_data_d [PORTS];

  // Direction along one dimension: 0 = stay, 1 = minus, 2 = plus.
  // Negative difference is corrected by a single +dim, matching the
  // (dest - my) mod dim rule for in-range coordinates.
  function automatic logic [1:0] dim_dir(input int dest, input int my, input int dim);
    int d;
    d = dest - my;
    if (d < 0) d = d + dim;
    if (dim == 1 || d == 0) return 2'd0;
    else if (d <= dim / 2)  return 2'd2;
    else                    return 2'd1;
  endfunction

  // Dimension-order route: X first, then Y, then Z, else eject locally.
  function automatic logic [2:0] route(input logic [DW-1:0] dst);
    logic [1:0] dx, dy, dz;
    dx = dim_dir(int'(dst[DW-1 -: XW]), MY_X, DIM_X);
    dy = dim_dir(int'(dst[DW-1-XW -: YW]), MY_Y, DIM_Y);
    dz = dim_dir(int'(dst[ZW-1:0]), MY_Z, DIM_Z);
    if (dx != 2'd0)      return {1'b0, dx};
    else if (dy != 2'd0) return {1'b0, dy} + 3'd2;
    else if (dz != 2'd0) return {1'b0, dz} + 3'd4;
    else                 return 3'd0;
  endfunction

  // FIFO status, head flit and route of each head.
  always_comb begin
    for (int unsigned p = 0; p < PORTS; p++) begin
      full[p]       = (wr_ptr_q[p][AW] != rd_ptr_q[p][AW]) &&
                      (wr_ptr_q[p][AW-1:0] == rd_ptr_q[p][AW-1:0]);
      empty[p]      = (wr_ptr_q[p] == rd_ptr_q[p]);
      push[p]       = IN_VALID[p] && !full[p];
      head[p]       = fifo_mem[p][rd_ptr_q[p][AW-1:0]];
      route_port[p] = route(head[p][FLIT_SIZE-1 -: DW]);
    end
  end

  assign IN_READY = ~full;

  // Round-robin arbitration per output and output register next state.
  always_comb begin
    logic        found;
    logic        can_load;
    int unsigned gsel;
    int unsigned idx;
    pop      = '0;
    found    = 1'b0;
    can_load = 1'b0;
    gsel     = 0;
    idx      = 0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      rr_d[o]        = rr_q[o];
      out_valid_d[o] = out_valid_q[o] && !OUT_READY[o];
      out_data_d[o]  = out_data_q[o];
      can_load       = !out_valid_q[o] || OUT_READY[o];
      found          = 1'b0;
      gsel           = 0;
      for (int unsigned k = 0; k < PORTS; k++) begin
        idx = 32'(rr_q[o]) + k;
        if (idx >= PORTS) idx = idx - PORTS;
        if (!found && can_load && !empty[idx] && route_port[idx] == 3'(o)) begin
          found = 1'b1;
          gsel  = idx;
        end
      end
      if (found) begin
        pop[gsel]      = 1'b1;
        out_valid_d[o] = 1'b1;
        out_data_d[o]  = head[gsel];
        rr_d[o]        = (gsel == PORTS - 1) ? 3'd0 : 3'(gsel + 1);
      end
    end
  end

  // FIFO pointer next state.
  always_comb begin
    for (int unsigned p = 0; p < PORTS; p++) begin
      wr_ptr_d[p] = wr_ptr_q[p] + ptr_t'(push[p]);
      rd_ptr_d[p] = rd_ptr_q[p] + ptr_t'(pop[p]);
    end
  end

  // FIFO storage write; contents need no reset since pointers gate reads.
  always_ff @(posedge CLK) begin
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (push[p]) fifo_mem[p][wr_ptr_q[p][AW-1:0]] <= IN_DATA[p*FLIT_SIZE +: FLIT_SIZE];
    end
  end

  // State registers: pointers, round-robin pointers, output stage.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid_q <= '0;
      for (int unsigned p = 0; p < PORTS; p++) begin
        wr_ptr_q[p]   <= '0;
        rd_ptr_q[p]   <= '0;
        rr_q[p]       <= '0;
        out_data_q[p] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      for (int unsigned p = 0; p < PORTS; p++) begin
        wr_ptr_q[p]   <= wr_ptr_d[p];
        rd_ptr_q[p]   <= rd_ptr_d[p];
        rr_q[p]       <= rr_d[p];
        out_data_q[p] <= out_data_d[p];
      end
    end
  end

  assign OUT_VALID = out_valid_q;

  for (genvar g = 0; g < PORTS; g++) begin : g_out
    assign OUT_DATA[g*FLIT_SIZE +: FLIT_SIZE] = out_data_q[g];
  end

endmodule

// File: tb/tb_torus_router.sv
// Testbench for torus_router: directed and randomized single-flit routing
// against a modular-arithmetic reference, reset, contention and back-pressure.
module tb_torus_router;

  logic         CLK;
  logic         RST_N;
  logic [223:0] in_data, out_data, in_data9, out_data9;
  logic [6:0]   in_valid, in_ready, out_valid, out_ready;
  logic [6:0]   in_valid9, in_ready9, out_valid9, out_ready9;

  int checks   = 0;
  int failures = 0;

  torus_router u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );

  torus_router #(.MY_X(9)) u_dut9 (
    .CLK(CLK), .RST_N(RST_N),
    .IN_DATA(in_data9), .IN_VALID(in_valid9), .IN_READY(in_ready9),
    .OUT_DATA(out_data9), .OUT_VALID(out_valid9), .OUT_READY(out_ready9)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int x, input int y, input int z, input logic [19:0] pl);
    return {4'(x), 4'(y), 4'(z), pl};
  endfunction

  // Reference routing on a 10x10x10 torus: shortest signed offset per axis.
  function automatic int route_model(input int x, input int y, input int z,
                                     input int mx, input int my, input int mz);
    int d;
    d = ((x - mx) % 10 + 10) % 10;
    if (d != 0) return (d <= 5) ? 2 : 1;
    d = ((y - my) % 10 + 10) % 10;
    if (d != 0) return (d <= 5) ? 4 : 3;
    d = ((z - mz) % 10 + 10) % 10;
    if (d != 0) return (d <= 5) ? 6 : 5;
    return 0;
  endfunction

  task automatic send1(input bit alt, input int src, input logic [31:0] f,
                       input int ep, input string tag);
    logic [6:0] ev;
    ev = '0;
    ev[ep] = 1'b1;
    if (alt) begin
      in_valid9 = '0; in_valid9[src] = 1'b1; in_data9[src*32 +: 32] = f;
      chk({tag, ":ready"}, 64'(in_ready9[src]), 64'd1);
    end else begin
      in_valid = '0; in_valid[src] = 1'b1; in_data[src*32 +: 32] = f;
      chk({tag, ":ready"}, 64'(in_ready[src]), 64'd1);
    end
    tick();
    in_valid  = '0;
    in_valid9 = '0;
    tick();
    if (alt) begin
      chk({tag, ":valid"}, 64'(out_valid9), 64'(ev));
      chk({tag, ":data"}, 64'(out_data9[ep*32 +: 32]), 64'(f));
    end else begin
      chk({tag, ":valid"}, 64'(out_valid), 64'(ev));
      chk({tag, ":data"}, 64'(out_data[ep*32 +: 32]), 64'(f));
    end
    tick();
  endtask

  initial begin
    int x, y, z, src, acc, got;
    logic rdy;
    int exp_src [9] = '{1, 3, 5, 1, 3, 5, 1, 3, 5};

    RST_N = 1'b0;
    in_data = '0; in_valid = '0; out_ready = '1;
    in_data9 = '0; in_valid9 = '0; out_ready9 = '1;
    tick();
    tick();
    chk("reset:out_valid", 64'(out_valid), 64'd0);
    chk("reset:out_data", 64'(out_data[63:0]), 64'd0);
    chk("reset:in_ready", 64'(in_ready), 64'h7F);
    RST_N = 1'b1;
    tick();

    // Directed routing on node (0,0,0).
    send1(0, 0, mk(3, 0, 0, 20'hABC), 2, "x_plus");
    send1(0, 0, mk(7, 0, 0, 20'h007), 1, "x_minus");
    send1(0, 0, mk(5, 0, 0, 20'h005), 2, "x_tie");
    send1(0, 0, mk(0, 0, 9, 20'h009), 5, "z_wrap");
    send1(0, 0, mk(0, 4, 6, 20'h046), 4, "dim_order");
    send1(0, 1, mk(0, 0, 0, 20'h111), 0, "eject");
    send1(0, 0, mk(0, 7, 0, 20'h070), 3, "y_minus");
    send1(0, 0, mk(0, 0, 3, 20'h003), 6, "z_plus");
    send1(0, 0, mk(0, 0, 0, 20'h0AA), 0, "loopback");

    // Directed routing on node (9,0,0).
    send1(1, 0, mk(0, 0, 0, 20'h900), 2, "wrap9_x");
    send1(1, 0, mk(9, 0, 0, 20'h999), 0, "wrap9_local");
    send1(1, 0, mk(8, 0, 0, 20'h988), 1, "wrap9_minus");
    send1(1, 0, mk(4, 0, 0, 20'h944), 2, "wrap9_tie");

    // Randomized single flits against the reference model.
    for (int i = 0; i < 40; i++) begin
      src = $urandom_range(0, 6);
      x = $urandom_range(0, 9); y = $urandom_range(0, 9); z = $urandom_range(0, 9);
      send1(0, src, mk(x, y, z, 20'($urandom)), route_model(x, y, z, 0, 0, 0), "rand0");
    end
    for (int i = 0; i < 20; i++) begin
      src = $urandom_range(0, 6);
      x = $urandom_range(0, 9); y = $urandom_range(0, 9); z = $urandom_range(0, 9);
      send1(1, src, mk(x, y, z, 20'($urandom)), route_model(x, y, z, 9, 0, 0), "rand9");
    end

    // Reset in the middle of blocked traffic.
    out_ready = '0;
    for (int c = 0; c < 3; c++) begin
      in_valid = '1;
      for (int p = 0; p < 7; p++)
        in_data[p*32 +: 32] = mk($urandom_range(0, 9), $urandom_range(0, 9),
                                 $urandom_range(0, 9), 20'($urandom));
      tick();
    end
    chk("pre_reset:busy", 64'(out_valid != 7'd0), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("midreset:out_valid", 64'(out_valid), 64'd0);
    chk("midreset:out_data_lo", 64'(out_data[63:0]), 64'd0);
    chk("midreset:out_data_hi", 64'(out_data[223:160]), 64'd0);
    chk("midreset:in_ready", 64'(in_ready), 64'h7F);
    in_valid = '0;
    out_ready = '1;
    tick();
    RST_N = 1'b1;
    tick();
    chk("post_reset:out_valid", 64'(out_valid), 64'd0);

    // Contention: inputs 1, 3, 5 each send three flits to port 0.
    for (int c = 0; c < 10; c++) begin
      in_valid = '0;
      if (c < 3) begin
        for (int s = 1; s <= 5; s += 2) begin
          in_valid[s] = 1'b1;
          in_data[s*32 +: 32] = mk(0, 0, 0, 20'(s * 16 + c));
        end
      end
      tick();
      if (c >= 1) begin
        chk("contend:valid", 64'(out_valid), 64'h01);
        chk("contend:order", 64'(out_data[31:0]),
            64'(mk(0, 0, 0, 20'(exp_src[c-1] * 16 + (c - 1) / 3))));
      end
    end
    tick();
    chk("contend:idle", 64'(out_valid), 64'd0);

    // Back-pressure: output 2 stalled, stream from port 0.
    out_ready[2] = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = '0;
      in_valid[0] = 1'b1;
      in_data[31:0] = mk(3, 0, 0, 20'(12'h100 + acc));
      rdy = in_ready[0];
      tick();
      if (rdy) acc++;
      if (c >= 1) begin
        chk("bp:valid", 64'(out_valid[2]), 64'd1);
        chk("bp:stable", 64'(out_data[95:64]), 64'(mk(3, 0, 0, 20'h100)));
      end
    end
    chk("bp:accepts", 64'(acc), 64'd5);
    chk("bp:in_ready_low", 64'(in_ready[0]), 64'd0);
    in_valid = '0;
    out_ready[2] = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid[2]) begin
        chk("bp:drain", 64'(out_data[95:64]), 64'(mk(3, 0, 0, 20'(12'h100 + got))));
        got++;
      end
      tick();
    end
    chk("bp:drain_count", 64'(got), 64'd5);
    chk("bp:empty", 64'(out_valid), 64'd0);
    chk("bp:in_ready_back", 64'(in_ready), 64'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
